// File: rtl/serial_parity_rx.sv
// serial_parity_rx: receive end of the serial parity link.
// Deserialises DATA_W data bits (LSB first) plus one parity bit. It checks
// the parity and presents the word with an error flag on a valid/ready
// output register. The output register applies backpressure to the line
// only while the parity bit of the next frame is waiting.
// Optional feature: define PAR_ERR_CNT_EN to add a saturating 16-bit count
// of frames that loaded the output register with a parity error.
module serial_parity_rx #(
  parameter int DATA_W     = 8,
  parameter int ODD_PARITY = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic              rx_start,
  input  logic              rx_bit,
  output logic              rx_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_par_err,
  output logic              frame_abort,
  output logic              busy
`ifdef PAR_ERR_CNT_EN
  ,
  output logic [15:0]       err_count
`endif
);

  localparam int                CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic              ODD_BIT  = (ODD_PARITY != 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY
  } state_t;

  // A one-bit frame goes straight from its first data bit to the parity bit.
  localparam state_t FIRST_ST = (DATA_W == 1) ? S_PARITY : S_DATA;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               par_q, par_d;
  logic [DATA_W-1:0]  shreg_q, shreg_d;
  logic               out_valid_q, out_valid_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic               out_err_q, out_err_d;
  logic               abort_q, abort_d;
  logic               accept;
  logic               load;
  logic               load_err;

  // The line stalls only when a finished frame would overwrite an untaken word.
  assign rx_ready    = !((state_q == S_PARITY) && out_valid_q && !out_ready);
  assign accept      = rx_valid && rx_ready;
  assign busy        = (state_q != S_IDLE);
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_par_err = out_err_q;
  assign frame_abort = abort_q;

  // Frame sequencing: collect data bits, track running parity, detect restarts.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    par_d    = par_q;
    shreg_d  = shreg_q;
    abort_d  = 1'b0;
    load     = 1'b0;
    load_err = par_q ^ rx_bit ^ ODD_BIT;
    if (accept) begin
      if (rx_start) begin
        // A start bit always opens a fresh frame; any partial frame is dropped.
        abort_d    = (state_q != S_IDLE);
        shreg_d    = '0;
        shreg_d[0] = rx_bit;
        par_d      = rx_bit;
        cnt_d      = CNT_ONE;
        state_d    = FIRST_ST;
      end else begin
        case (state_q)
          S_DATA: begin
            for (int i = 0; i < DATA_W; i++) begin
              if (cnt_q == CNT_W'(i)) shreg_d[i] = rx_bit;
            end
            par_d = par_q ^ rx_bit;
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_d == CNT_LAST) state_d = S_PARITY;
          end
          S_PARITY: begin
            load    = 1'b1;
            cnt_d   = '0;
            par_d   = 1'b0;
            state_d = S_IDLE;
          end
          default: begin
            // Bits outside a frame are dropped silently.
          end
        endcase
      end
    end
  end

  // Output register: a new load wins over the consumer's take in the same cycle.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = shreg_q;
      out_err_d   = load_err;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Control and output state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      par_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      par_q       <= par_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
      abort_q     <= abort_d;
    end
  end

  // Shift register holds only in-flight data bits; a reset leaves it stale but unused.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
  end

`ifdef PAR_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign err_count = err_cnt_q;

  // Count only frames that actually reach the output register with bad parity.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (load && load_err) err_cnt_d = sat_inc16(err_cnt_q);
  end

  // Error counter register.
  always_ff @(posedge clk) begin
    if (rst) err_cnt_q <= 16'd0;
    else     err_cnt_q <= err_cnt_d;
  end
`endif

endmodule

// File: tb/tb_serial_parity_rx.sv
// Bench for serial_parity_rx: frame table, directed corner sequences and
// random traffic checked against a queue-based frame model.
module tb_serial_parity_rx;

  localparam int DATA_W     = 8;
  localparam int ODD_PARITY = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rx_valid, rx_start, rx_bit, out_ready;
  logic rx_ready, out_valid, out_par_err, frame_abort, busy;
  logic [DATA_W-1:0] out_data;
  logic o_rx_ready, o_out_valid, o_out_par_err, o_frame_abort, o_busy;
  logic [DATA_W-1:0] o_out_data;
`ifdef PAR_ERR_CNT_EN
  logic [15:0] err_count, o_err_count;
`endif

  serial_parity_rx #(.DATA_W(DATA_W), .ODD_PARITY(ODD_PARITY)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_start(rx_start), .rx_bit(rx_bit),
    .rx_ready(rx_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_par_err(out_par_err), .frame_abort(frame_abort), .busy(busy)
`ifdef PAR_ERR_CNT_EN
    , .err_count(err_count)
`endif
  );

  serial_parity_rx #(.DATA_W(DATA_W), .ODD_PARITY(1)) dut_odd (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_start(rx_start), .rx_bit(rx_bit),
    .rx_ready(o_rx_ready), .out_valid(o_out_valid), .out_ready(out_ready),
    .out_data(o_out_data), .out_par_err(o_out_par_err), .frame_abort(o_frame_abort), .busy(o_busy)
`ifdef PAR_ERR_CNT_EN
    , .err_count(o_err_count)
`endif
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: the frame in progress is a queue of received bits.
  int          mbits[$];
  bit          mvalid;
  logic [7:0]  mdata;
  bit          merr;
  bit          mabort;
  int          mcnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit model_ready(input bit ordy);
    return !((mbits.size() == DATA_W) && mvalid && !ordy);
  endfunction

  // One clock cycle: drive inputs, check readiness, clock, update model, check outputs.
  task automatic tick(input bit r, input bit v, input bit s, input bit b, input bit ordy);
    bit exp_rdy, acc, load, nerr, nabort;
    logic [7:0] ndata;
    int ones;
    rst = r; rx_valid = v; rx_start = s; rx_bit = b; out_ready = ordy;
    #1;
    exp_rdy = model_ready(ordy);
    if (!r) chk("rx_ready", rx_ready, exp_rdy);
    @(posedge clk);
    #1;
    if (r) begin
      mbits.delete(); mvalid = 0; mdata = 0; merr = 0; mabort = 0; mcnt = 0;
    end else begin
      acc = v && exp_rdy; load = 0; nerr = 0; nabort = 0; ndata = 0;
      if (acc) begin
        if (s) begin
          nabort = (mbits.size() > 0);
          mbits.delete();
          mbits.push_back(int'(b));
        end else if (mbits.size() == DATA_W) begin
          ones = int'(b) + ODD_PARITY;
          foreach (mbits[i]) begin
            ones += mbits[i];
            ndata[i] = (mbits[i] != 0);
          end
          nerr = (ones % 2) != 0;
          load = 1;
          mbits.delete();
        end else if (mbits.size() > 0) begin
          mbits.push_back(int'(b));
        end
      end
      if (load) begin
        mvalid = 1; mdata = ndata; merr = nerr;
        if (nerr && mcnt < 65535) mcnt++;
      end else if (mvalid && ordy) begin
        mvalid = 0;
      end
      mabort = nabort;
    end
    chk("out_valid", out_valid, mvalid);
    chk("out_data", out_data, mdata);
    chk("out_par_err", out_par_err, merr);
    chk("frame_abort", frame_abort, mabort);
    chk("busy", busy, mbits.size() > 0);
`ifdef PAR_ERR_CNT_EN
    chk("err_count", err_count, mcnt);
`endif
  endtask

  task automatic send_frame(input logic [7:0] d, input bit p, input bit ordy);
    for (int i = 0; i < DATA_W; i++) tick(0, 1, (i == 0), d[i], ordy);
    tick(0, 1, 0, p, ordy);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         par;
    bit         exp_err;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{8'hA5, 1'b0, 1'b0};
    tbl[1] = '{8'hA5, 1'b1, 1'b1};
    tbl[2] = '{8'h00, 1'b0, 1'b0};
    tbl[3] = '{8'hFF, 1'b0, 1'b0};
    tbl[4] = '{8'hFF, 1'b1, 1'b1};
    tbl[5] = '{8'h01, 1'b0, 1'b1};
    tbl[6] = '{8'h80, 1'b1, 1'b0};
    tbl[7] = '{8'h3C, 1'b1, 1'b1};

    rst = 1; rx_valid = 0; rx_start = 0; rx_bit = 0; out_ready = 1;
    mbits.delete(); mvalid = 0; mdata = 0; merr = 0; mabort = 0; mcnt = 0;
    @(posedge clk);
    #1;
    tick(1, 0, 0, 0, 1);
    tick(1, 0, 0, 0, 1);
    chk("rst_rx_ready", rx_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_par_err", out_par_err, 0);
    chk("rst_abort", frame_abort, 0);
    chk("rst_busy", busy, 0);

    // Frame table, both parity senses.
    for (int i = 0; i < 8; i++) begin
      send_frame(tbl[i].data, tbl[i].par, 1);
      chk("tbl_valid", out_valid, 1);
      chk("tbl_data", out_data, tbl[i].data);
      chk("tbl_err", out_par_err, tbl[i].exp_err);
      chk("tbl_odd_valid", o_out_valid, 1);
      chk("tbl_odd_data", o_out_data, tbl[i].data);
      chk("tbl_odd_err", o_out_par_err, !tbl[i].exp_err);
      chk("tbl_odd_busy", o_busy, 0);
      chk("tbl_odd_abort", o_frame_abort, 0);
      chk("tbl_odd_ready", o_rx_ready, 1);
      tick(0, 0, 0, 0, 1);
      chk("tbl_valid_one_cycle", out_valid, 0);
    end

    // Backpressure: second frame's parity bit must wait for the consumer.
    send_frame(8'h3C, 0, 0);
    chk("bp_first_data", out_data, 8'h3C);
    for (int i = 0; i < DATA_W; i++) tick(0, 1, (i == 0), 1'b1, 0);
    for (int k = 0; k < 3; k++) begin
      tick(0, 1, 0, 0, 0);
      chk("bp_rx_ready", rx_ready, 0);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_data", out_data, 8'h3C);
    end
    tick(0, 1, 0, 0, 1);
    chk("bp_reload_valid", out_valid, 1);
    chk("bp_reload_data", out_data, 8'hFF);
    chk("bp_reload_err", out_par_err, 0);
    tick(0, 0, 0, 0, 0);
    chk("bp_keep_valid", out_valid, 1);
    tick(0, 0, 0, 0, 1);
    chk("bp_drain", out_valid, 0);

    // Abort: restart after three bits.
    tick(0, 1, 1, 1, 1);
    tick(0, 1, 0, 0, 1);
    tick(0, 1, 0, 1, 1);
    tick(0, 1, 1, 1, 1);
    chk("abort_pulse", frame_abort, 1);
    tick(0, 1, 0, 0, 1);
    chk("abort_pulse_end", frame_abort, 0);
    for (int i = 0; i < 6; i++) tick(0, 1, 0, 0, 1);
    tick(0, 1, 0, 1, 1);
    chk("abort_valid", out_valid, 1);
    chk("abort_data", out_data, 8'h01);
    chk("abort_err", out_par_err, 0);
    tick(0, 0, 0, 0, 1);

    // Reset with a held word and a partial frame.
    send_frame(8'hC3, 0, 0);
    for (int i = 0; i < 4; i++) tick(0, 1, (i == 0), 1'b1, 0);
    chk("mid_busy", busy, 1);
    tick(1, 0, 0, 0, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_err", out_par_err, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", rx_ready, 1);
    send_frame(8'h5A, 0, 1);
    chk("post_rst_data", out_data, 8'h5A);
    chk("post_rst_err", out_par_err, 0);
    chk("post_rst_valid", out_valid, 1);
    tick(0, 0, 0, 0, 1);

`ifdef PAR_ERR_CNT_EN
    tick(1, 0, 0, 0, 1);
    for (int k = 0; k < 3; k++) send_frame(8'hA5, 1, 1);
    for (int i = 0; i < 3; i++) tick(0, 1, (i == 0), 1'b1, 1);
    send_frame(8'h0F, 0, 1);
    chk("errcnt_three", err_count, 3);
    tick(0, 0, 0, 0, 1);
    force dut.err_cnt_q = 16'hFFFF;
    #1;
    release dut.err_cnt_q;
    mcnt = 65535;
    send_frame(8'hA5, 1, 1);
    chk("errcnt_saturate", err_count, 16'hFFFF);
    tick(1, 0, 0, 0, 1);
`endif

    // Random traffic against the model.
    for (int n = 0; n < 800; n++) begin
      tick(($urandom_range(99) == 0), ($urandom_range(9) < 7), ($urandom_range(99) < 12),
           1'($urandom), ($urandom_range(3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
